// File: rtl/bf16_mul_arbiter.sv
// bf16_mul_arbiter: round-robin front end that time-shares one external
// combinational bfloat16 multiplier among NUM_REQ requesters and returns
// each product on a single tagged response channel.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Requesters hold valid and operands until their ready bit is
// seen. The response channel holds valid, data, error and id stable until
// rsp_ready_i is sampled high.
module bf16_mul_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 16,
    parameter int ERROR_WIDTH = 2,
    parameter int ID_WIDTH    = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b_i,
    output logic [DATA_WIDTH-1:0]         mul_in1_o,
    output logic [DATA_WIDTH-1:0]         mul_in2_o,
    input  logic [DATA_WIDTH-1:0]         mul_out_i,
    input  logic [ERROR_WIDTH-1:0]        mul_error_i,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic [DATA_WIDTH-1:0]         rsp_data_o,
    output logic [ERROR_WIDTH-1:0]        rsp_error_o,
    output logic [ID_WIDTH-1:0]           rsp_id_o,
    output logic [15:0]                   ops_done_o,
    output logic [1:0]                    state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  op_a_q, op_b_q;
    logic [DATA_WIDTH-1:0]  rsp_data_q;
    logic [ERROR_WIDTH-1:0] rsp_error_q;
    logic [ID_WIDTH-1:0]    cur_id_q;
    logic [ID_WIDTH-1:0]    last_grant_q;
    logic [15:0]            ops_done_q;

    logic                   grant_found;
    logic [ID_WIDTH-1:0]    grant_id;
    logic [ID_WIDTH-1:0]    cand;
    int                     idx;
    logic                   accept;
    logic                   rsp_fire;

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        idx         = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(last_grant_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            cand = ID_WIDTH'(idx);
            if (!grant_found && req_valid_i[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
        end
    end

    // Next-state and handshake outputs; ready is only offered while idle.
    always_comb begin
        state_d     = state_q;
        req_ready_o = '0;
        accept      = 1'b0;
        rsp_fire    = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    req_ready_o = NUM_REQ'(1) << grant_id;
                    accept      = 1'b1;
                    state_d     = EXEC;
                end
            end
            EXEC: state_d = RESP;
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_fire = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Operand capture on accept, result capture at the end of EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a_q       <= '0;
            op_b_q       <= '0;
            cur_id_q     <= '0;
            last_grant_q <= ID_WIDTH'(NUM_REQ - 1);
            rsp_data_q   <= '0;
            rsp_error_q  <= '0;
        end else begin
            if (accept) begin
                op_a_q       <= req_a_i[grant_id*DATA_WIDTH +: DATA_WIDTH];
                op_b_q       <= req_b_i[grant_id*DATA_WIDTH +: DATA_WIDTH];
                cur_id_q     <= grant_id;
                last_grant_q <= grant_id;
            end
            if (state_q == EXEC) begin
                rsp_data_q  <= mul_out_i;
                rsp_error_q <= mul_error_i;
            end
        end
    end

    // Completed-response counter; only written on a response handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        ops_done_q <= '0;
        else if (rsp_fire) ops_done_q <= ops_done_q + 16'd1;
    end

    assign mul_in1_o   = op_a_q;
    assign mul_in2_o   = op_b_q;
    assign rsp_valid_o = (state_q == RESP);
    assign rsp_data_o  = rsp_data_q;
    assign rsp_error_o = rsp_error_q;
    assign rsp_id_o    = cur_id_q;
    assign ops_done_o  = ops_done_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_bf16_mul_arbiter.sv
// Bench for bf16_mul_arbiter: a bfloat16 multiplier stub, a cycle-level
// reference of the arbitration/response protocol and a response scoreboard.
module tb_bf16_mul_arbiter;
  localparam int N = 4;
  localparam int P_IDLE = 0, P_EXEC = 1, P_RESP = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [N-1:0]    req_v = '0;
  logic [15:0]     a_arr[N];
  logic [15:0]     b_arr[N];
  logic [N-1:0]    req_ready;
  logic [N*16-1:0] req_a, req_b;
  logic [15:0]     mul_in1, mul_in2, mul_out;
  logic [1:0]      mul_error;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [15:0]     rsp_data;
  logic [1:0]      rsp_error;
  logic [1:0]      rsp_id;
  logic [15:0]     ops_done;
  logic [1:0]      dbg_state;
  logic            err_force = 1'b0;

  for (genvar gi = 0; gi < N; gi++) begin : g_pack
    assign req_a[gi*16 +: 16] = a_arr[gi];
    assign req_b[gi*16 +: 16] = b_arr[gi];
  end

  bf16_mul_arbiter #(.NUM_REQ(N), .DATA_WIDTH(16), .ERROR_WIDTH(2), .ID_WIDTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_v), .req_ready_o(req_ready),
    .req_a_i(req_a), .req_b_i(req_b),
    .mul_in1_o(mul_in1), .mul_in2_o(mul_in2),
    .mul_out_i(mul_out), .mul_error_i(mul_error),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data), .rsp_error_o(rsp_error), .rsp_id_o(rsp_id),
    .ops_done_o(ops_done), .state_o(dbg_state)
  );

  // bfloat16 multiply (truncating), returns {error, product}.
  // error: 0 ok, 1 overflow, 3 underflow, 2 when the stub is forced.
  function automatic logic [17:0] mul_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic ef);
    int ea, eb, ma, mb, p, e, fr;
    logic s;
    s  = a[15] ^ b[15];
    ea = int'(a[14:7]);
    eb = int'(b[14:7]);
    if (ef) return {2'b10, 16'h7F80};
    if (ea == 0 || eb == 0) return {2'b00, s, 15'h0};
    ma = 128 + int'(a[6:0]);
    mb = 128 + int'(b[6:0]);
    p  = ma * mb;
    e  = ea + eb - 127;
    if (p >= 32768) begin e = e + 1; fr = (p >> 8) & 127; end
    else fr = (p >> 7) & 127;
    if (e >= 255) return {2'b01, s, 8'hFF, 7'h0};
    if (e <= 0) return {2'b11, s, 15'h0};
    return {2'b00, s, e[7:0], fr[6:0]};
  endfunction

  assign {mul_error, mul_out} = mul_model(mul_in1, mul_in2, err_force);

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [19:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference of the protocol: phase, last grant, completed count.
  int          m_phase = P_IDLE;
  int          m_last = N - 1;
  logic [15:0] m_ops = '0;
  int          cyc = 0;
  int          last_acc = -1;
  int          grant_log[$];
  int          grant_cyc[$];
  int          pop_cyc = 0;
  logic [15:0] ld[N];
  logic [1:0]  le[N];
  int          mon_g;
  int          mon_idx;
  logic [N-1:0] mon_rdy;

  // Monitor: checks every cycle at the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      cyc++;
      mon_g = -1;
      if (m_phase == P_IDLE) begin
        for (int k = 1; k <= N; k++) begin
          mon_idx = (m_last + k) % N;
          if (mon_g < 0 && req_v[mon_idx]) mon_g = mon_idx;
        end
      end
      mon_rdy = (mon_g >= 0) ? (N'(1) << mon_g) : '0;
      check("req_ready", 32'(req_ready), 32'(mon_rdy));
      check("rsp_valid", 32'(rsp_valid), 32'(m_phase == P_RESP));
      check("ops_done", 32'(ops_done), 32'(m_ops));
      case (m_phase)
        P_IDLE: begin
          if (mon_g >= 0) begin
            exp_q.push_back({2'(mon_g), mul_model(a_arr[mon_g], b_arr[mon_g], err_force)});
            m_last = mon_g;
            last_acc = mon_g;
            grant_log.push_back(mon_g);
            grant_cyc.push_back(cyc);
            m_phase = P_EXEC;
          end
        end
        P_EXEC: m_phase = P_RESP;
        default: begin
          if (exp_q.size() == 0) begin
            check("rsp_unexpected", 32'(rsp_valid), 32'h0);
          end else begin
            check("rsp_payload", 32'({rsp_id, rsp_error, rsp_data}), 32'(exp_q[0]));
            if (rsp_ready) begin
              ld[rsp_id] = rsp_data;
              le[rsp_id] = rsp_error;
              pop_cyc = cyc;
              void'(exp_q.pop_front());
              m_ops = m_ops + 16'd1;
              m_phase = P_IDLE;
            end
          end
        end
      endcase
    end
  end

  // ---------------- driver ----------------
  int   mode = 0;        // 0: drop valid on accept, 1: keep requesting, 2: random
  logic rand_ready = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
    if (last_acc >= 0) begin
      if (mode != 1) req_v[last_acc] = 1'b0;
      last_acc = -1;
    end
    if (mode == 2) begin
      for (int i = 0; i < N; i++) begin
        if (!req_v[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            req_v[i] = 1'b1;
            a_arr[i] = 16'($urandom);
            b_arr[i] = 16'($urandom);
          end
        end else if ($urandom_range(0, 29) == 0) begin
          req_v[i] = 1'b0;
        end
      end
    end
    if (rand_ready) rsp_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic drain(input int budget, input string name);
    int i;
    for (i = 0; i < budget; i++) begin
      if (req_v == '0 && exp_q.size() == 0 && m_phase == P_IDLE) break;
      step();
    end
    check(name, 32'(i < budget), 32'h1);
  endtask

  task automatic issue(input int r, input logic [15:0] a, input logic [15:0] b);
    a_arr[r] = a;
    b_arr[r] = b;
    req_v[r] = 1'b1;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int sz;
    int i;
    for (int r = 0; r < N; r++) begin a_arr[r] = '0; b_arr[r] = '0; end

    // Reset state.
    repeat (3) @(posedge clk);
    #2;
    check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset_rsp_data", 32'(rsp_data), 32'h0);
    check("reset_rsp_error", 32'(rsp_error), 32'h0);
    check("reset_rsp_id", 32'(rsp_id), 32'h0);
    check("reset_ops_done", 32'(ops_done), 32'h0);
    check("reset_mul_in1", 32'(mul_in1), 32'h0);
    check("reset_mul_in2", 32'(mul_in2), 32'h0);
    check("reset_req_ready", 32'(req_ready), 32'h0);
    rst_n = 1'b1;

    // All four requesting continuously: grants rotate every 3 cycles.
    rsp_ready = 1'b1;
    mode = 1;
    issue(0, 16'h3F80, 16'h3F80);
    issue(1, 16'h4000, 16'h4000);
    issue(2, 16'h4040, 16'h4000);
    issue(3, 16'hBF80, 16'h4040);
    repeat (17) step();
    check("rr_grant_count", 32'(grant_log.size() >= 5), 32'h1);
    if (grant_log.size() >= 5) begin
      for (int k = 0; k < 5; k++) check("rr_order", 32'(grant_log[k]), 32'(k % N));
      for (int k = 1; k < 5; k++) check("rr_spacing", 32'(grant_cyc[k] - grant_cyc[k-1]), 32'd3);
    end
    check("rr_req2_data", 32'(ld[2]), 32'h40C0);
    mode = 0;
    drain(60, "drain_rr");

    // Single request latency and product.
    issue(0, 16'h3F80, 16'h4000);
    drain(20, "drain_single");
    check("single_latency", 32'(pop_cyc - grant_cyc[grant_cyc.size()-1]), 32'd2);
    check("single_data", 32'(ld[0]), 32'h4000);
    check("single_id", 32'(grant_log[grant_log.size()-1]), 32'h0);

    // Backpressure: others keep requesting while the response is held.
    rsp_ready = 1'b0;
    issue(0, 16'h4100, 16'h3FC0);
    issue(1, 16'h4080, 16'h4080);
    issue(3, 16'h3E80, 16'h4200);
    i = 0;
    while (m_phase != P_RESP && i < 10) begin step(); i++; end
    check("bp_reach_resp", 32'(m_phase == P_RESP), 32'h1);
    repeat (10) step();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    repeat (3) step();
    rsp_ready = 1'b1;
    drain(60, "drain_bp");

    // Error passthrough from the multiplier stub.
    err_force = 1'b1;
    issue(3, 16'h1234, 16'h5678);
    drain(20, "drain_err");
    check("err_code", 32'(le[3]), 32'h2);
    check("err_data", 32'(ld[3]), 32'h7F80);
    err_force = 1'b0;

    // Reset during EXEC: transaction dropped, requester 0 first afterwards.
    issue(1, 16'h4000, 16'h4040);
    i = 0;
    while (m_phase != P_EXEC && i < 10) begin step(); i++; end
    check("rst_reach_exec", 32'(m_phase == P_EXEC), 32'h1);
    #1;
    rst_n = 1'b0;
    m_phase = P_IDLE; m_last = N - 1; m_ops = '0; exp_q.delete(); last_acc = -1;
    #1;
    check("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("midrst_rsp_data", 32'(rsp_data), 32'h0);
    check("midrst_rsp_id", 32'(rsp_id), 32'h0);
    check("midrst_ops_done", 32'(ops_done), 32'h0);
    check("midrst_mul_in1", 32'(mul_in1), 32'h0);
    check("midrst_req_ready", 32'(req_ready), 32'h0);
    req_v = '0;
    repeat (2) @(posedge clk);
    for (int r = N - 1; r >= 0; r--) issue(r, 16'(16'h3F80 + r), 16'h4000);
    sz = grant_log.size();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drain(60, "drain_after_rst");
    check("post_rst_first_grant", 32'(grant_log[sz]), 32'h0);

    // Counter wrap.
    force dut.ops_done_q = 16'hFFFF;
    #1;
    release dut.ops_done_q;
    m_ops = 16'hFFFF;
    issue(2, 16'h3F80, 16'h3F80);
    drain(20, "drain_wrap");
    check("ops_wrap", 32'(ops_done), 32'h0);

    // Randomised traffic with random backpressure.
    mode = 2;
    rand_ready = 1'b1;
    repeat (400) step();
    mode = 0;
    rand_ready = 1'b0;
    rsp_ready = 1'b1;
    drain(100, "drain_random");
    check("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
